// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives program memory, and hands
// one instruction at a time to decode with relative-branch redirect and halt.
//
// state | meaning
// IDLE  | out of reset, no fetching, waiting for start
// RUN   | fetching sequentially from pc into the output register
// DRAIN | last word (SIZE-1) loaded, waiting for decode to take it
// DONE  | finished or halted, waiting for start to restart at 0
module fetch_controller #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  input  logic [15:0]           pm_data,
  output logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  br_valid,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic [10:0]           br_offset,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           fetch_count
);

  localparam int EXT_W = (ADDR_WIDTH > 11) ? ADDR_WIDTH : 11;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_instr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  r_instr_valid;
  logic [15:0]           r_fetch_count;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [15:0]           w_instr_nxt;
  logic [ADDR_WIDTH-1:0] w_instr_pc_nxt;
  logic                  w_instr_valid_nxt;
  logic [15:0]           w_fetch_count_nxt;
  logic                  w_xfer;
  logic                  w_active;
  logic [EXT_W-1:0]      w_off_ext;
  logic [ADDR_WIDTH-1:0] w_target;

  // Sign-extend far enough to cover the address width, then wrap mod SIZE.
  assign w_off_ext = EXT_W'($signed(br_offset));
  assign w_target  = br_pc + ADDR_WIDTH'(1) + w_off_ext[ADDR_WIDTH-1:0];
  assign w_xfer    = r_instr_valid && instr_ready;
  assign w_active  = (r_state == S_RUN) || (r_state == S_DRAIN);

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_fetch_count_nxt = r_fetch_count;

    if (w_active) begin
      if (w_xfer && (r_fetch_count != 16'hFFFF))
        w_fetch_count_nxt = r_fetch_count + 16'd1;

      if (halt) begin
        w_instr_valid_nxt = 1'b0;
        w_state_nxt       = S_DONE;
      end else if (br_valid) begin
        w_pc_nxt          = w_target;
        w_instr_valid_nxt = 1'b0;
        w_state_nxt       = S_RUN;
      end else if (r_state == S_RUN) begin
        if (!r_instr_valid || instr_ready) begin
          w_instr_nxt       = pm_data;
          w_instr_pc_nxt    = r_pc;
          w_instr_valid_nxt = 1'b1;
          // The last word ends the program rather than wrapping to 0.
          if (r_pc == LAST_ADDR)
            w_state_nxt = S_DRAIN;
          else
            w_pc_nxt = r_pc + ADDR_WIDTH'(1);
        end
      end else if (w_xfer) begin
        w_instr_valid_nxt = 1'b0;
        w_state_nxt       = S_DONE;
      end
    end else if (start) begin
      w_state_nxt       = S_RUN;
      w_pc_nxt          = '0;
      w_fetch_count_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_count <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_fetch_count <= w_fetch_count_nxt;
      r_busy        <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done        <= (w_state_nxt == S_DONE);
    end
  end

  assign pm_addr     = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign fetch_count = r_fetch_count;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction fetch sequencer sitting between `program_memory` and the decode stage. It owns the program counter, drives the memory's combinational read address, and presents one 16-bit instruction at a time to decode over a valid/ready handshake. It applies relative branch redirects from the execute stage and controls run, halt and end-of-memory completion.

## Interface
Parameters:
- ADDR_WIDTH, 6: program memory address width; SIZE = 2^ADDR_WIDTH words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  begin execution at address 0; honoured only in IDLE or DONE.
- halt  in  1  stop fetching immediately; honoured in RUN and DRAIN.
- pm_addr  out  ADDR_WIDTH  read address to program memory; equals pc.
- pm_data  in  16  combinational read data for pm_addr.
- instr  out  16  held instruction word.
- instr_pc  out  ADDR_WIDTH  address the held instruction was fetched from.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  decode accepts the instruction this cycle.
- br_valid  in  1  branch taken; redirect fetch.
- br_pc  in  ADDR_WIDTH  address of the branch instruction.
- br_offset  in  11  signed two's-complement offset (instruction bits [10:0]).
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- fetch_count  out  16  number of completed handshakes since the last start; saturates at 16'hFFFF.

## Operation
- Reset values: state IDLE, pc 0, instr 0, instr_pc 0, instr_valid 0, busy 0, done 0, fetch_count 0.
- Handshake: a transfer occurs when instr_valid && instr_ready. Once instr_valid is high, instr/instr_pc hold until a transfer, flush or halt.
- The output register loads when (!instr_valid || instr_ready) && state==RUN && !br_valid && !halt. A load sets instr <= pm_data, instr_pc <= pc, instr_valid <= 1, pc <= pc+1 (mod SIZE).
- Branch target = (br_pc + 1 + sign_extend(br_offset)) truncated to ADDR_WIDTH bits; it wraps modulo SIZE.
- br_valid (RUN or DRAIN): pc <= target, instr_valid <= 0 (flush), state <= RUN, and no load in that cycle. A transfer in the same cycle still counts in fetch_count.
- fetch_count increments on every transfer and clears on an accepted start.
- States:
  - IDLE: no fetching. On start: state RUN, pc 0, fetch_count 0.
  - RUN: normal fetch. A load from pc==SIZE-1 moves to DRAIN instead of wrapping to address 0.
  - DRAIN: no loads; waits for the last instruction. A transfer without br_valid moves to DONE. br_valid moves to RUN at the target.
  - DONE: done=1, instr_valid=0. On start: restart exactly as from IDLE.
- halt in RUN or DRAIN: instr_valid <= 0, state DONE. halt has priority over br_valid and the load. A transfer in the same cycle still counts.
- start in RUN or DRAIN is ignored. br_valid in IDLE or DONE is ignored.
- rst_n low overrides everything, including mid-fetch and mid-branch, and returns all state to the reset values.

## Timing
- start sampled at edge t: state RUN, pc 0 at t. PM[0] is loaded at edge t+1, so instr_valid is first high in the cycle after edge t+1.
- Steady state with instr_ready held high: one instruction per cycle, consecutive addresses.
- Branch: br_valid sampled at edge t flushes at t. The target instruction is loaded at edge t+1, giving a one-bubble penalty.
- pm_addr is driven directly from the pc register with no combinational path from inputs. pm_data is captured in the same cycle as its address.
- busy and done are registered state decodes and are valid in the cycle after the transition edge.

## Test plan
- Reset/start: hold rst_n low 2 cycles, then pulse start. All outputs are 0 until the first instruction; instr_pc sequence 0,1,2,3 with instr==PM[n]; fetch_count==4 after 4 accepted.
- Backpressure: instr_ready low for 3 cycles while valid at pc 5. instr/instr_pc stay stable at 5; pc does not pass 6; no word is lost or duplicated after release.
- Forward branch: br_valid with br_pc=22, br_offset=1 -> one bubble, next instr_pc=24. Backward branch: br_pc=5, br_offset=11'h7FE -> next instr_pc=4.
- End of memory: run to 63 -> DRAIN; accept 63 -> done=1, instr_valid=0. Repeat with br_valid at br_pc=63, br_offset=1 -> target wraps to 1, state RUN.
- Halt and priority: halt together with br_valid and a transfer -> state DONE, instr_valid 0, fetch_count incremented by 1, pc unchanged. start in DONE restarts at 0 with fetch_count 0.
- Reset mid-run: assert rst_n low while instr_valid=1 at pc 17 -> all outputs return to their reset values on the next edge.
